digicode_multi: RTL
===================

// Module: digicode_multi
// PURPOSE
// Parametrised keypad access controller and successor to the fixed 5-digit digicode.
// Adds the following features:
//  - configurable code length
//  - code reprogrammable at run time
//  - internal inter-key timeout, in addition to the external timeout
//  - timed door pulse and timed alarm
//  - lockout after repeated failures
// Sits between the keypad decoder (one-cycle key strobes) and the door/alarm drivers.
// PARAMETERS
// CODE_LEN       5          digits in the access code (1..8)
// DEFAULT_CODE   20'h40B82  code after reset; digit0 in [3:0], so this is 2,8,B,0,4
// MAX_TRIES      3          consecutive failures before LOCKED (>=1)
// TIMEOUT_CYC    64         max clk cycles between keys in ENTRY
// DOOR_CYC       16         cycles door stays high
// ALARM_CYC      32         cycles alarm stays high on a non-lockout failure
// PORTS
// clk          in   1              system clock, all state on rising edge
// reset        in   1              asynchronous, active-low
// key_valid    in   1              one-cycle strobe, code is valid this cycle
// code         in   4              key: 0-9, A(1010), B(1011), C(1100)=cancel, P(1101)=push
// daytime      in   1              level; sampled on the cycle a P key is accepted
// timeout      in   1              external abort strobe, same effect as the internal timeout
// prog_en      in   1              load prog_code into code register (IDLE only)
// prog_code    in   4*CODE_LEN     new code, digit i at [4i+3:4i]
// door         out  1              door release, registered
// alarm        out  1              alarm, registered
// locked       out  1              lockout active, registered
// entry_cnt    out  $clog2(CODE_LEN+1)  correct digits accepted so far
// fail_cnt     out  $clog2(MAX_TRIES+1) consecutive failures
// BEHAVIOUR
// Clock and reset: one clock; reset is asynchronous and active-low.
// Reset state:
//  - state=IDLE; door=alarm=locked=0; entry_cnt=fail_cnt=0; all timers 0.
//  - Code register = DEFAULT_CODE.
//  - A reset asserted mid-operation aborts immediately, including from LOCKED.
// Timing: all outputs are registered. A key accepted at edge t shows its effect on outputs after edge t+1.
// States: IDLE, ENTRY, OPEN, ALARM, LOCKED.
// IDLE:
//  - key == code digit 0 -> ENTRY, entry_cnt=1 (CODE_LEN=1 -> OPEN).
//  - P with daytime=1 -> OPEN.
//  - P at night, or a wrong digit/A/B -> FAIL.
//  - C -> ignored.
//  - prog_en=1 -> code reg <= prog_code. Any key in the same cycle is discarded.
// ENTRY:
//  - key == digit[entry_cnt] -> entry_cnt+1; the last digit goes to OPEN.
//  - Wrong key -> FAIL.
//  - C -> IDLE, entry_cnt=0, no failure counted.
//  - P: daytime=1 -> OPEN; daytime=0 -> FAIL.
//  - Timeout (external strobe, or TIMEOUT_CYC cycles without key_valid) -> FAIL.
//  - Inter-key timer restarts on every accepted key.
//  - A timeout in the same cycle as key_valid: the timeout wins and the key is dropped.
//  - prog_en is ignored.
// FAIL (transition action, not a state):
//  - fail_cnt+1 (saturating) and entry_cnt=0.
//  - If the new fail_cnt == MAX_TRIES -> LOCKED; otherwise -> ALARM.
// OPEN:
//  - door=1 for exactly DOOR_CYC cycles, then IDLE.
//  - fail_cnt=0 on entry.
//  - Keys, timeout and prog_en are ignored.
// ALARM:
//  - alarm=1 for exactly ALARM_CYC cycles, then IDLE.
//  - Keys are ignored.
// LOCKED:
//  - alarm=1 and locked=1 until reset.
//  - All inputs are ignored.
// Keys: codes E/F are treated as wrong keys. Code-register digits >= C can never be matched.
// Counters: door/alarm/timeout counters are sized $clog2(max+1) with no wrap. They hold at the terminal count for the exit cycle.
// TESTING
// 1. Night, keys 2,8,B,0,4 -> door=1 for 16 cycles, then IDLE, fail_cnt=0.
// 2. Daytime=1, key P from IDLE and from entry_cnt=3 -> door; daytime=0 with P -> alarm for 32 cycles, fail_cnt=1.
// 3. Wrong digit at each position 0..4 -> alarm=1 for 32 cycles, entry_cnt=0, fail_cnt increments.
// 4. Keys 2,8 then 64 idle cycles -> alarm. Keys 2,8 then timeout strobe -> alarm. Key + timeout in the same cycle -> alarm.
// 5. Three consecutive failures -> locked=alarm=1 persisting 1000 cycles; correct code ignored; reset clears everything.
// 6. prog_en with code 1,2,3,4,5 in IDLE -> 1,2,3,4,5 opens and 2,8,B,0,4 fails. prog_en during ENTRY -> ignored. C mid-entry -> IDLE, fail_cnt unchanged.

Source files
------------

// File: rtl/digicode_multi.sv
// Keypad access controller: configurable code length, run-time reprogrammable
// code, inter-key timeout, timed door pulse / alarm and lockout after repeated
// failures. All outputs are registered copies of the internal state, so a key
// accepted at edge t becomes visible on the outputs after edge t+1.
module digicode_multi #(
   parameter int                    CODE_LEN     = 5,
   parameter logic [4*CODE_LEN-1:0] DEFAULT_CODE = 20'h40B82,
   parameter int                    MAX_TRIES    = 3,
   parameter int                    TIMEOUT_CYC  = 64,
   parameter int                    DOOR_CYC     = 16,
   parameter int                    ALARM_CYC    = 32,
   localparam int                   EW           = $clog2(CODE_LEN + 1),
   localparam int                   FW           = $clog2(MAX_TRIES + 1)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    key_valid,
   input  logic [3:0]              code,
   input  logic                    daytime,
   input  logic                    timeout,
   input  logic                    prog_en,
   input  logic [4*CODE_LEN-1:0]   prog_code,
   output logic                    door,
   output logic                    alarm,
   output logic                    locked,
   output logic [EW-1:0]           entry_cnt,
   output logic [FW-1:0]           fail_cnt
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam int DW = $clog2(DOOR_CYC + 1);
   localparam int AW = $clog2(ALARM_CYC + 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ENTRY  = 3'd1,
      S_OPEN   = 3'd2,
      S_ALARM  = 3'd3,
      S_LOCKED = 3'd4
   } state_t;

   state_t                  state_q, state_d;
   logic [4*CODE_LEN-1:0]   code_reg_q, code_reg_d;
   logic [EW-1:0]           ent_q, ent_d;
   logic [FW-1:0]           fails_q, fails_d;
   logic [TW-1:0]           to_cnt_q, to_cnt_d;
   logic [DW-1:0]           door_cnt_q, door_cnt_d;
   logic [AW-1:0]           alarm_cnt_q, alarm_cnt_d;
   logic                    door_q, door_d;
   logic                    alarm_q, alarm_d;
   logic                    locked_q, locked_d;
   logic [EW-1:0]           entry_cnt_q, entry_cnt_d;
   logic [FW-1:0]           fail_cnt_q, fail_cnt_d;

   logic [3:0]              cur_digit_s;
   logic                    is_p_s, is_c_s, hit_s, abort_s;
   logic                    go_fail_s, go_open_s;

   // Key decode: compare against the expected digit; digits >= C never match.
   always_comb begin
      cur_digit_s = code_reg_q[4*ent_q +: 4];
      is_p_s      = (code == 4'hD);
      is_c_s      = (code == 4'hC);
      hit_s       = (code < 4'hC) && (code == cur_digit_s);
      // external strobe, or the last allowed idle cycle passing with no key
      abort_s     = timeout || ((to_cnt_q == TW'(TIMEOUT_CYC - 1)) && !key_valid);
   end

   // Next-state, counters and registered-output computation.
   always_comb begin
      state_d     = state_q;
      code_reg_d  = code_reg_q;
      ent_d       = ent_q;
      fails_d     = fails_q;
      to_cnt_d    = to_cnt_q;
      door_cnt_d  = door_cnt_q;
      alarm_cnt_d = alarm_cnt_q;
      go_fail_s   = 1'b0;
      go_open_s   = 1'b0;

      case (state_q)
         S_IDLE: begin
            to_cnt_d    = '0;
            door_cnt_d  = '0;
            alarm_cnt_d = '0;
            if (prog_en) begin
               code_reg_d = prog_code;      // a key in the same cycle is dropped
            end else if (key_valid) begin
               if (is_p_s) begin
                  go_open_s = daytime;
                  go_fail_s = !daytime;
               end else if (is_c_s) begin
                  state_d = S_IDLE;
               end else if (hit_s) begin
                  if (CODE_LEN == 1) begin
                     go_open_s = 1'b1;
                  end else begin
                     state_d = S_ENTRY;
                     ent_d   = EW'(1);
                  end
               end else begin
                  go_fail_s = 1'b1;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ENTRY: begin
            if (abort_s) begin
               go_fail_s = 1'b1;            // timeout beats a simultaneous key
               to_cnt_d  = TW'(TIMEOUT_CYC);
            end else if (key_valid) begin
               to_cnt_d = '0;
               if (is_c_s) begin
                  state_d = S_IDLE;
                  ent_d   = '0;
               end else if (is_p_s) begin
                  go_open_s = daytime;
                  go_fail_s = !daytime;
               end else if (hit_s) begin
                  if (ent_q == EW'(CODE_LEN - 1)) begin
                     go_open_s = 1'b1;
                  end else begin
                     ent_d = ent_q + 1'b1;
                  end
               end else begin
                  go_fail_s = 1'b1;
               end
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end
         S_OPEN: begin
            if (door_cnt_q == DW'(DOOR_CYC - 1)) begin
               door_cnt_d = DW'(DOOR_CYC);  // hold terminal count on exit
               state_d    = S_IDLE;
            end else begin
               door_cnt_d = door_cnt_q + 1'b1;
            end
         end
         S_ALARM: begin
            if (alarm_cnt_q == AW'(ALARM_CYC - 1)) begin
               alarm_cnt_d = AW'(ALARM_CYC);
               state_d     = S_IDLE;
            end else begin
               alarm_cnt_d = alarm_cnt_q + 1'b1;
            end
         end
         S_LOCKED: begin
            state_d = S_LOCKED;             // only reset leaves lockout
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (go_fail_s) begin
         ent_d       = '0;
         alarm_cnt_d = '0;
         if (fails_q != FW'(MAX_TRIES)) begin
            fails_d = fails_q + 1'b1;
         end else begin
            fails_d = fails_q;
         end
         if (fails_q >= FW'(MAX_TRIES - 1)) begin
            state_d = S_LOCKED;
         end else begin
            state_d = S_ALARM;
         end
      end else if (go_open_s) begin
         ent_d      = '0;
         fails_d    = '0;
         door_cnt_d = '0;
         state_d    = S_OPEN;
      end else begin
         fails_d = fails_d;
      end

      door_d      = (state_q == S_OPEN);
      alarm_d     = (state_q == S_ALARM) || (state_q == S_LOCKED);
      locked_d    = (state_q == S_LOCKED);
      entry_cnt_d = ent_q;
      fail_cnt_d  = fails_q;
   end

   // State, code register, counters and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         code_reg_q  <= DEFAULT_CODE;
         ent_q       <= '0;
         fails_q     <= '0;
         to_cnt_q    <= '0;
         door_cnt_q  <= '0;
         alarm_cnt_q <= '0;
         door_q      <= 1'b0;
         alarm_q     <= 1'b0;
         locked_q    <= 1'b0;
         entry_cnt_q <= '0;
         fail_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         code_reg_q  <= code_reg_d;
         ent_q       <= ent_d;
         fails_q     <= fails_d;
         to_cnt_q    <= to_cnt_d;
         door_cnt_q  <= door_cnt_d;
         alarm_cnt_q <= alarm_cnt_d;
         door_q      <= door_d;
         alarm_q     <= alarm_d;
         locked_q    <= locked_d;
         entry_cnt_q <= entry_cnt_d;
         fail_cnt_q  <= fail_cnt_d;
      end
   end

   assign door      = door_q;
   assign alarm     = alarm_q;
   assign locked    = locked_q;
   assign entry_cnt = entry_cnt_q;
   assign fail_cnt  = fail_cnt_q;

endmodule
